// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the 4164 DRAM sequencing controller.
// Contents:
//   state_t            - controller FSM states
//   DEF_*              - default timing constants
//   PHASE_W            - width of the per-state phase counter
package dram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ROW  = 3'd1,
        COL  = 3'd2,
        CAS  = 3'd3,
        REF  = 3'd4,
        PRE  = 3'd5
    } state_t;

    localparam int DEF_REFRESH_INTERVAL = 30;
    localparam int DEF_REF_BITS         = 7;
    localparam int DEF_CAS_CYCLES       = 2;
    localparam int DEF_REF_RAS_CYCLES   = 2;
    localparam int DEF_PRECHARGE_CYCLES = 2;

    // Phase counter covers CAS, REF and PRE dwell times; all are well under 256.
    localparam int PHASE_W = 8;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer.
// Counts 0 .. REFRESH_INTERVAL-1 and wraps; each wrap raises the pending flag.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   clear    in   controller accepted the pending refresh this cycle
//   pending  out  a refresh is owed
//   overrun  out  one-cycle pulse: interval expired while a refresh was still owed
module dram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic pending,
    output logic overrun
);

    localparam int CNT_W = $clog2(REFRESH_INTERVAL);

    logic [CNT_W-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    logic             wrap;

    always_comb begin
        wrap    = (count_q == CNT_W'(REFRESH_INTERVAL - 1));
        count_d = wrap ? '0 : count_q + CNT_W'(1);
        // A wrap always leaves a refresh owed, even if the old one is being
        // consumed in the same cycle: that is a fresh interval's refresh.
        pending_d = wrap | (pending_q & ~clear);
        // An old request being accepted this cycle is not an overrun.
        overrun   = wrap & pending_q & ~clear;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/dram_controller_4164.sv
// Sequencing controller for a 4164-style 64Kx1 DRAM behind two 74157 muxes.
// Runs CPU accesses (ROW -> COL -> CAS -> PRE) and RAS-only refreshes
// (REF -> PRE) from an internal interval timer.
// Handshake: req is a level sampled only in IDLE together with wr; once
// sampled the access always completes and ack pulses for exactly one cycle
// in the last CAS cycle. The requester drops req after ack; a req still high
// in IDLE starts another access. A pending refresh beats req in IDLE.
// Ports:
//   C, nR             clock, asynchronous active-low reset
//   req, wr           access request and direction (1 = write)
//   ack, busy         access done pulse, controller not idle
//   ras_n/cas_n/we_n  DRAM strobes
//   mux_select        74157 select (0 = row half, 1 = column half)
//   mux_strobe_n      74157 enable, low only in ROW/COL/CAS
//   ref_addr_oe_n     refresh address driver enable, low only in REF
//   ref_addr          current refresh row
//   refresh_overrun   interval expired with a refresh still owed
//   dbg_state         current FSM state
module dram_controller_4164
    import dram_ctrl_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int REF_BITS         = DEF_REF_BITS,
    parameter int CAS_CYCLES       = DEF_CAS_CYCLES,
    parameter int REF_RAS_CYCLES   = DEF_REF_RAS_CYCLES,
    parameter int PRECHARGE_CYCLES = DEF_PRECHARGE_CYCLES
) (
    input  logic                C,
    input  logic                nR,
    input  logic                req,
    input  logic                wr,
    output logic                ack,
    output logic                busy,
    output logic                ras_n,
    output logic                cas_n,
    output logic                we_n,
    output logic                mux_select,
    output logic                mux_strobe_n,
    output logic                ref_addr_oe_n,
    output logic [REF_BITS-1:0] ref_addr,
    output logic                refresh_overrun,
    output state_t              dbg_state
);

    localparam logic [PHASE_W-1:0] CAS_LAST = PHASE_W'(CAS_CYCLES - 1);
    localparam logic [PHASE_W-1:0] REF_LAST = PHASE_W'(REF_RAS_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PRE_LAST = PHASE_W'(PRECHARGE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic                wr_q, wr_d;
    logic [REF_BITS-1:0] ref_addr_q, ref_addr_d;
    logic                pending, clear;

    // Registered pin drivers so the DRAM and mux see glitch-free strobes.
    logic ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
    logic mux_select_q, mux_select_d, mux_strobe_n_q, mux_strobe_n_d;
    logic ref_addr_oe_n_q, ref_addr_oe_n_d, ack_q, ack_d, busy_q, busy_d;

    dram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_timer (
        .clk    (C),
        .rst_n  (nR),
        .clear  (clear),
        .pending(pending),
        .overrun(refresh_overrun)
    );

    // Next state.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        wr_d       = wr_q;
        ref_addr_d = ref_addr_q;
        clear      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    state_d = REF;
                    phase_d = '0;
                    clear   = 1'b1;
                end else if (req) begin
                    state_d = ROW;
                    wr_d    = wr;
                end
            end
            ROW: state_d = COL;
            COL: begin
                state_d = CAS;
                phase_d = '0;
            end
            CAS: begin
                if (phase_q == CAS_LAST) begin
                    state_d = PRE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            REF: begin
                if (phase_q == REF_LAST) begin
                    state_d    = PRE;
                    phase_d    = '0;
                    ref_addr_d = ref_addr_q + REF_BITS'(1);
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            PRE: begin
                if (phase_q == PRE_LAST) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Pin values are decoded from the state being entered, so the registered
    // pins line up with the registered state.
    always_comb begin
        ras_n_d         = ~(state_d inside {ROW, COL, CAS, REF});
        cas_n_d         = ~(state_d == CAS);
        we_n_d          = ~((state_d inside {COL, CAS}) & wr_d);
        mux_select_d    = state_d inside {COL, CAS};
        mux_strobe_n_d  = ~(state_d inside {ROW, COL, CAS});
        ref_addr_oe_n_d = ~(state_d == REF);
        busy_d          = (state_d != IDLE);
        ack_d           = (state_d == CAS) && (phase_d == CAS_LAST);
    end

    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            state_q         <= IDLE;
            phase_q         <= '0;
            wr_q            <= 1'b0;
            ref_addr_q      <= '0;
            ras_n_q         <= 1'b1;
            cas_n_q         <= 1'b1;
            we_n_q          <= 1'b1;
            mux_select_q    <= 1'b0;
            mux_strobe_n_q  <= 1'b1;
            ref_addr_oe_n_q <= 1'b1;
            ack_q           <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            wr_q            <= wr_d;
            ref_addr_q      <= ref_addr_d;
            ras_n_q         <= ras_n_d;
            cas_n_q         <= cas_n_d;
            we_n_q          <= we_n_d;
            mux_select_q    <= mux_select_d;
            mux_strobe_n_q  <= mux_strobe_n_d;
            ref_addr_oe_n_q <= ref_addr_oe_n_d;
            ack_q           <= ack_d;
            busy_q          <= busy_d;
        end
    end

    assign ras_n         = ras_n_q;
    assign cas_n         = cas_n_q;
    assign we_n          = we_n_q;
    assign mux_select    = mux_select_q;
    assign mux_strobe_n  = mux_strobe_n_q;
    assign ref_addr_oe_n = ref_addr_oe_n_q;
    assign ack           = ack_q;
    assign busy          = busy_q;
    assign ref_addr      = ref_addr_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dram_controller_4164.sv
// Directed bench for dram_controller_4164.
// Cycle numbers count rising edges since the last reset release; outputs are
// sampled on the falling edge following that rising edge.
module tb_dram_controller_4164;
    import dram_ctrl_pkg::*;

    // Pin vector: {ras_n, cas_n, we_n, mux_select, mux_strobe_n, ref_addr_oe_n, busy}
    localparam logic [6:0] P_IDLE  = 7'b1110110;
    localparam logic [6:0] P_PRE   = 7'b1110111;
    localparam logic [6:0] P_REF   = 7'b0110101;
    localparam logic [6:0] P_ROW   = 7'b0110011;
    localparam logic [6:0] P_COL_R = 7'b0111011;
    localparam logic [6:0] P_CAS_R = 7'b0011011;
    localparam logic [6:0] P_COL_W = 7'b0101011;
    localparam logic [6:0] P_CAS_W = 7'b0001011;

    // ---------------- clock / reset ----------------
    logic       C = 1'b0;
    logic       nR = 1'b0;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic       ack, busy, ras_n, cas_n, we_n, mux_select, mux_strobe_n;
    logic       ref_addr_oe_n, refresh_overrun;
    logic [6:0] ref_addr;
    state_t     dbg_state;
    logic [6:0] pins;

    always #5 C = ~C;

    dram_controller_4164 dut (
        .C              (C),
        .nR             (nR),
        .req            (req),
        .wr             (wr),
        .ack            (ack),
        .busy           (busy),
        .ras_n          (ras_n),
        .cas_n          (cas_n),
        .we_n           (we_n),
        .mux_select     (mux_select),
        .mux_strobe_n   (mux_strobe_n),
        .ref_addr_oe_n  (ref_addr_oe_n),
        .ref_addr       (ref_addr),
        .refresh_overrun(refresh_overrun),
        .dbg_state      (dbg_state)
    );

    assign pins = {ras_n, cas_n, we_n, mux_select, mux_strobe_n, ref_addr_oe_n, busy};

    int cyc;
    always @(posedge C or negedge nR) begin
        if (!nR) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // ---------------- scoreboard state ----------------
    // Each entry: {ack cycle[15:0], we_n at ack}
    logic [16:0] exp_q[$];
    logic [16:0] exp_e;
    int          checks = 0;
    int          errors = 0;
    int          ovr_cnt = 0;

    // ---------------- driver / check tasks ----------------
    task automatic wait_cyc(input int n);
        if (cyc > n) begin
            errors++;
            $display("FAIL schedule cyc=%0d already past target=%0d", cyc, n);
        end
        while (cyc < n) @(negedge C);
    endtask

    task automatic chk_pins(input string name, input logic [6:0] exp);
        checks++;
        if (pins !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d pins=%b expected=%b", name, cyc, pins, exp);
        end
    endtask

    task automatic chk_ref(input string name, input logic [6:0] exp);
        checks++;
        if (ref_addr !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d ref_addr=%0d expected=%0d", name, cyc, ref_addr, exp);
        end
    endtask

    task automatic push_ack(input int c, input logic w);
        exp_q.push_back({c[15:0], w});
    endtask

    // ---------------- monitor ----------------
    always @(negedge C) begin
        if (nR) begin
            if (ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected cyc=%0d we_n=%b expected=no ack", cyc, we_n);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({cyc[15:0], we_n} !== exp_e) begin
                        errors++;
                        $display("FAIL ack_event got cyc=%0d we_n=%b expected cyc=%0d we_n=%b",
                                 cyc, we_n, exp_e[16:1], exp_e[0]);
                    end
                end
            end
            if (cas_n === 1'b0) begin
                checks++;
                if (ras_n !== 1'b0) begin
                    errors++;
                    $display("FAIL cas_without_ras cyc=%0d ras_n=%b expected=0", cyc, ras_n);
                end
            end
            if (refresh_overrun) ovr_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d expected=bench finished", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int soak_acks[24] = '{76, 83, 90, 102, 109, 116, 123, 135, 142, 149, 161, 168,
                          175, 182, 194, 201, 208, 220, 227, 234, 241, 253, 260, 267};

    initial begin
        repeat (3) @(negedge C);
        chk_pins("reset_pins", P_IDLE);
        chk_ref("reset_ref_addr", 7'd0);
        checks++;
        if (dbg_state !== IDLE || ack !== 1'b0 || refresh_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state state=%0d ack=%b ovr=%b expected=0 0 0",
                     dbg_state, ack, refresh_overrun);
        end
        nR = 1'b1;

        // Idle until the first refresh at the interval wrap.
        for (int c = 1; c <= 30; c++) begin
            wait_cyc(c);
            chk_pins("idle_wait", P_IDLE);
        end
        chk_ref("idle_ref_addr", 7'd0);
        wait_cyc(31); chk_pins("ref1_a", P_REF); chk_ref("ref1_addr_during", 7'd0);
        wait_cyc(32); chk_pins("ref1_b", P_REF);
        wait_cyc(33); chk_pins("ref1_pre_a", P_PRE); chk_ref("ref1_addr_after", 7'd1);
        wait_cyc(34); chk_pins("ref1_pre_b", P_PRE);
        wait_cyc(35); chk_pins("ref1_idle", P_IDLE);

        // Read: sampled at edge 37.
        wait_cyc(36); req = 1'b1; wr = 1'b0; push_ack(40, 1'b1);
        wait_cyc(37); chk_pins("rd_row", P_ROW); req = 1'b0;
        wait_cyc(38); chk_pins("rd_col", P_COL_R);
        wait_cyc(39); chk_pins("rd_cas_a", P_CAS_R);
        wait_cyc(40); chk_pins("rd_cas_b", P_CAS_R);
        wait_cyc(41); chk_pins("rd_pre_a", P_PRE);
        wait_cyc(42); chk_pins("rd_pre_b", P_PRE);
        wait_cyc(43); chk_pins("rd_idle", P_IDLE);

        // Write: sampled at edge 44, wr dropped after sampling.
        req = 1'b1; wr = 1'b1; push_ack(47, 1'b0);
        wait_cyc(44); chk_pins("wr_row", P_ROW); req = 1'b0;
        wait_cyc(45); chk_pins("wr_col", P_COL_W); wr = 1'b0;
        wait_cyc(46); chk_pins("wr_cas_a", P_CAS_W);
        wait_cyc(47); chk_pins("wr_cas_b", P_CAS_W);
        wait_cyc(48); chk_pins("wr_pre", P_PRE);
        wait_cyc(50); chk_pins("wr_idle", P_IDLE);

        // Refresh pending and req together at edge 61: refresh first.
        wait_cyc(60); chk_pins("coll_idle", P_IDLE); req = 1'b1; wr = 1'b0; push_ack(69, 1'b1);
        wait_cyc(61); chk_pins("coll_ref_a", P_REF);
        wait_cyc(62); chk_pins("coll_ref_b", P_REF);
        wait_cyc(63); chk_pins("coll_pre", P_PRE); chk_ref("coll_ref_addr", 7'd2);
        wait_cyc(65); chk_pins("coll_gap_idle", P_IDLE);
        wait_cyc(66); chk_pins("coll_row", P_ROW); req = 1'b0;
        wait_cyc(67); chk_pins("coll_col", P_COL_R);
        wait_cyc(68); chk_pins("coll_cas", P_CAS_R);
        wait_cyc(72); chk_pins("coll_idle_end", P_IDLE);

        // Continuous req for 200 cycles with refreshes interleaved.
        req = 1'b1; wr = 1'b0;
        foreach (soak_acks[i]) push_ack(soak_acks[i], 1'b1);
        wait_cyc(272); req = 1'b0;
        wait_cyc(276);
        chk_pins("soak_idle", P_IDLE);
        chk_ref("soak_ref_addr", 7'd9);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL soak_acks_missing outstanding=%0d expected=0", exp_q.size());
        end
        checks++;
        if (ovr_cnt != 0) begin
            errors++;
            $display("FAIL soak_overrun count=%0d expected=0", ovr_cnt);
        end

        // Idle refreshes until the refresh row counter wraps.
        wait_cyc(3842); chk_pins("wrap_ref", P_REF); chk_ref("wrap_before", 7'd127);
        wait_cyc(3843); chk_pins("wrap_pre", P_PRE); chk_ref("wrap_after", 7'd0);

        // Reset in the middle of a write access.
        wait_cyc(3846); chk_pins("rst_idle", P_IDLE); req = 1'b1; wr = 1'b1;
        wait_cyc(3847); chk_pins("rst_row", P_ROW); req = 1'b0;
        wait_cyc(3848); chk_pins("rst_col", P_COL_W);
        wait_cyc(3849); chk_pins("rst_cas", P_CAS_W);
        #2 nR = 1'b0;
        #1 chk_pins("rst_async_pins", P_IDLE);
        checks++;
        if (ack !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL rst_async_state ack=%b state=%0d expected=0 0", ack, dbg_state);
        end
        @(negedge C); @(negedge C);
        nR = 1'b1;
        wait_cyc(5); chk_pins("post_rst_idle", P_IDLE); chk_ref("post_rst_ref_addr", 7'd0);
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL post_rst_state state=%0d expected=%0d", dbg_state, IDLE);
        end
        wait_cyc(12);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_acks_missing outstanding=%0d expected=0", exp_q.size());
        end
        checks++;
        if (ovr_cnt != 0) begin
            errors++;
            $display("FAIL final_overrun count=%0d expected=0", ovr_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
